// File: rtl/myproject_dense_mac_seq_pkg.sv
// Shared definitions for the dense-layer neuron MAC sequencer: FSM state
// encoding and the width of the multiplier core's full-precision product.
package myproject_dense_mac_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int PROD_WIDTH = 25;

endpackage

// File: rtl/myproject_mul_mul_16s_9s_25_1_1.sv
// Combinational signed 16x9 multiplier core producing a full 25-bit product.
module myproject_mul_mul_16s_9s_25_1_1
  import myproject_dense_mac_seq_pkg::*;
(
  input  logic [15:0]           din0,
  input  logic [8:0]            din1,
  output logic [PROD_WIDTH-1:0] dout
);

  // Both operands are sign-extended to the product width before multiplying,
  // so the result is exact and never overflows.
  assign dout = PROD_WIDTH'($signed(din0)) * PROD_WIDTH'($signed(din1));

endmodule

// File: rtl/myproject_dense_mac_seq.sv
// One dense-layer neuron: walks N_IN data/weight pairs through a shared
// multiplier, accumulates the products onto a bias, and returns the sum
// under the ap_ctrl_hs handshake.
module myproject_dense_mac_seq
  import myproject_dense_mac_seq_pkg::*;
#(
  parameter int N_IN       = 4,
  parameter int ADDR_WIDTH = 2,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ap_start,
  output logic                  ap_done,
  output logic                  ap_idle,
  output logic                  ap_ready,
  input  logic [ACC_WIDTH-1:0]  bias,
  output logic [ADDR_WIDTH-1:0] data_address0,
  output logic                  data_ce0,
  input  logic [15:0]           data_q0,
  output logic [ADDR_WIDTH-1:0] weight_address0,
  output logic                  weight_ce0,
  input  logic [8:0]            weight_q0,
  output logic [ACC_WIDTH-1:0]  ap_return
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(N_IN - 1);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic                    drain_q, drain_d;
  logic                    rd_vld_q;
  logic [PROD_WIDTH-1:0]   mul_out;
  logic [PROD_WIDTH-1:0]   prod_q;
  logic                    prod_vld_q;
  logic [ACC_WIDTH-1:0]    prod_ext;
  logic [ACC_WIDTH-1:0]    acc_q, acc_d;
  logic [ACC_WIDTH-1:0]    ret_q;
  logic                    accept;

  assign accept = (state_q == S_IDLE) && ap_start;

  // State register.
  always_ff @(posedge ap_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    if (ap_rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: DRAIN lasts two cycles to cover the ROM read and the
  // product register before the final accumulate lands.
  always_comb begin
    // NOTE: defaulting every comb output first keeps unlisted paths from
    // inferring latches.
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (ap_start)          state_d = S_RUN;
      S_RUN:   if (idx_q == LAST_IDX) state_d = S_DRAIN;
      S_DRAIN: if (drain_q)           state_d = S_DONE;
      S_DONE:                         state_d = S_IDLE;
      default:                        state_d = S_IDLE;
    endcase
  end

  // Handshake and memory-port outputs decoded from the current state.
  always_comb begin
    ap_idle  = (state_q == S_IDLE);
    ap_done  = (state_q == S_DONE);
    ap_ready = (state_q == S_DONE);
    data_ce0 = (state_q == S_RUN);
  end

  assign weight_ce0      = data_ce0;
  assign data_address0   = idx_q;
  assign weight_address0 = idx_q;
  assign ap_return       = ret_q;

  // Read index: cleared on acceptance, stops at the last entry so the
  // address holds (and never wraps) once reads finish.
  always_comb begin
    idx_d = idx_q;
    if (accept)                                     idx_d = '0;
    else if (state_q == S_RUN && idx_q != LAST_IDX) idx_d = idx_q + ADDR_WIDTH'(1);
  end

  assign drain_d = (state_q == S_DRAIN);

  myproject_mul_mul_16s_9s_25_1_1 u_mul (
    .din0 (data_q0),
    .din1 (weight_q0),
    .dout (mul_out)
  );

  assign prod_ext = ACC_WIDTH'($signed(prod_q));

  // Accumulator: loaded with the bias at acceptance, then adds each valid
  // product; wraps modulo 2^ACC_WIDTH.
  always_comb begin
    acc_d = acc_q;
    if (accept)          acc_d = bias;
    else if (prod_vld_q) acc_d = acc_q + prod_ext;
  end

  // Counter, read-valid / product pipeline, accumulator and result registers.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      idx_q      <= '0;
      drain_q    <= 1'b0;
      rd_vld_q   <= 1'b0;
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
      acc_q      <= '0;
      ret_q      <= '0;
    end else begin
      idx_q      <= idx_d;
      drain_q    <= drain_d;
      rd_vld_q   <= data_ce0;
      prod_vld_q <= rd_vld_q;
      if (rd_vld_q) prod_q <= mul_out;
      acc_q      <= acc_d;
      // Capture the finished sum (including the last product) on DONE entry.
      if (state_q == S_DRAIN && drain_q) ret_q <= acc_d;
    end
  end

endmodule

// File: tb/tb_myproject_dense_mac_seq.sv
// Directed bench for the dense MAC sequencer: three instances cover the
// default configuration, a 25-bit accumulator and a single-input neuron.
module tb_myproject_dense_mac_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] bias;

  logic [15:0] mem_data [4];
  logic [8:0]  mem_wt   [4];

  int checks = 0;
  int errors = 0;

  // Instance a: N_IN=4, ACC_WIDTH=32
  logic        a_done, a_idle, a_ready, a_dce, a_wce;
  logic [1:0]  a_daddr, a_waddr;
  logic [15:0] a_dq;
  logic [8:0]  a_wq;
  logic [31:0] a_ret;

  // Instance b: N_IN=4, ACC_WIDTH=25
  logic        b_done, b_idle, b_ready, b_dce, b_wce;
  logic [1:0]  b_daddr, b_waddr;
  logic [15:0] b_dq;
  logic [8:0]  b_wq;
  logic [24:0] b_ret;

  // Instance c: N_IN=1, ADDR_WIDTH=1
  logic        c_done, c_idle, c_ready, c_dce, c_wce;
  logic [0:0]  c_daddr, c_waddr;
  logic [15:0] c_dq;
  logic [8:0]  c_wq;
  logic [31:0] c_ret;

  myproject_dense_mac_seq #(.N_IN(4), .ADDR_WIDTH(2), .ACC_WIDTH(32)) dut_a (
    .ap_clk(clk), .ap_rst(rst), .ap_start(start),
    .ap_done(a_done), .ap_idle(a_idle), .ap_ready(a_ready),
    .bias(bias),
    .data_address0(a_daddr), .data_ce0(a_dce), .data_q0(a_dq),
    .weight_address0(a_waddr), .weight_ce0(a_wce), .weight_q0(a_wq),
    .ap_return(a_ret)
  );

  myproject_dense_mac_seq #(.N_IN(4), .ADDR_WIDTH(2), .ACC_WIDTH(25)) dut_b (
    .ap_clk(clk), .ap_rst(rst), .ap_start(start),
    .ap_done(b_done), .ap_idle(b_idle), .ap_ready(b_ready),
    .bias(bias[24:0]),
    .data_address0(b_daddr), .data_ce0(b_dce), .data_q0(b_dq),
    .weight_address0(b_waddr), .weight_ce0(b_wce), .weight_q0(b_wq),
    .ap_return(b_ret)
  );

  myproject_dense_mac_seq #(.N_IN(1), .ADDR_WIDTH(1), .ACC_WIDTH(32)) dut_c (
    .ap_clk(clk), .ap_rst(rst), .ap_start(start),
    .ap_done(c_done), .ap_idle(c_idle), .ap_ready(c_ready),
    .bias(bias),
    .data_address0(c_daddr), .data_ce0(c_dce), .data_q0(c_dq),
    .weight_address0(c_waddr), .weight_ce0(c_wce), .weight_q0(c_wq),
    .ap_return(c_ret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 1-cycle-latency ROM models; junk is driven whenever the read was not enabled.
  always @(posedge clk) begin
    a_dq <= a_dce ? mem_data[a_daddr] : 16'($urandom);
    a_wq <= a_wce ? mem_wt[a_waddr]   : 9'($urandom);
    b_dq <= b_dce ? mem_data[b_daddr] : 16'($urandom);
    b_wq <= b_wce ? mem_wt[b_waddr]   : 9'($urandom);
    c_dq <= c_dce ? mem_data[c_daddr] : 16'($urandom);
    c_wq <= c_wce ? mem_wt[c_waddr]   : 9'($urandom);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int d0, input int d1, input int d2, input int d3,
                      input int w0, input int w1, input int w2, input int w3);
    mem_data[0] = 16'(d0); mem_data[1] = 16'(d1);
    mem_data[2] = 16'(d2); mem_data[3] = 16'(d3);
    mem_wt[0]   = 9'(w0);  mem_wt[1]   = 9'(w1);
    mem_wt[2]   = 9'(w2);  mem_wt[3]   = 9'(w3);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    bias  = '0;
    load(0, 0, 0, 0, 0, 0, 0, 0);

    // ---- Reset state ----
    step(3);
    check("rst_idle",   32'(a_idle),  1);
    check("rst_done",   32'(a_done),  0);
    check("rst_ready",  32'(a_ready), 0);
    check("rst_ce",     32'(a_dce),   0);
    check("rst_wce",    32'(a_wce),   0);
    check("rst_addr",   32'(a_daddr), 0);
    check("rst_ret",    a_ret,        0);
    check("rst_ret_b",  32'(b_ret),   0);
    check("rst_idle_c", 32'(c_idle),  1);
    rst = 1'b0;
    step(2);

    // ---- Basic: [1,-2,3,-4].[5,6,-7,8] + 10 = -50 ----
    load(1, -2, 3, -4, 5, 6, -7, 8);
    start = 1'b1; bias = 32'd10;
    step(1);
    start = 1'b0; bias = 32'd77;
    for (int k = 0; k < 4; k++) begin
      check("basic_ce",    32'(a_dce),   1);
      check("basic_wce",   32'(a_wce),   1);
      check("basic_addr",  32'(a_daddr), 32'(k));
      check("basic_waddr", 32'(a_waddr), 32'(k));
      check("basic_idle",  32'(a_idle),  0);
      step(1);
    end
    check("basic_ce_off",    32'(a_dce),   0);
    check("basic_addr_hold", 32'(a_daddr), 3);
    step(1);
    check("basic_done_early", 32'(a_done), 0);
    step(1);
    check("basic_done",  32'(a_done),  1);
    check("basic_ready", 32'(a_ready), 1);
    check("basic_idle7", 32'(a_idle),  0);
    check("basic_ret",   a_ret,        32'(-50));
    step(1);
    check("basic_done_end", 32'(a_done), 0);
    check("basic_idle_end", 32'(a_idle), 1);
    check("basic_ret_held", a_ret,       32'(-50));
    step(2);

    // ---- Start pulse while busy is ignored: 4*(2*3) + 0 = 24 ----
    load(2, 2, 2, 2, 3, 3, 3, 3);
    start = 1'b1; bias = 32'd0;
    step(1);
    start = 1'b0;
    step(3);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(2);
    check("busy_done", 32'(a_done), 1);
    check("busy_ret",  a_ret,       24);
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("busy_no_rerun", 32'(a_done), 0);
      check("busy_idle",     32'(a_idle), 1);
      check("busy_ret_held", a_ret,       24);
    end
    step(1);

    // ---- Extremes: 4*(-32768*-256) = 2^25; wraps to 0 at 25 bits ----
    load(-32768, -32768, -32768, -32768, -256, -256, -256, -256);
    start = 1'b1; bias = 32'd0;
    step(1);
    start = 1'b0;
    step(6);
    check("ext_done",   32'(a_done), 1);
    check("ext_ret32",  a_ret,       33554432);
    check("ext_done25", 32'(b_done), 1);
    check("ext_ret25",  32'(b_ret),  0);
    step(2);

    // ---- Back-to-back with start held: 4+5=9, then 4-1=3 ----
    load(1, 1, 1, 1, 1, 1, 1, 1);
    start = 1'b1; bias = 32'd5;
    step(1);
    bias = 32'hFFFF_FFFF;
    step(6);
    check("b2b_done1", 32'(a_done), 1);
    check("b2b_ret1",  a_ret,       9);
    step(1);
    check("b2b_gap_idle", 32'(a_idle), 1);
    check("b2b_gap_done", 32'(a_done), 0);
    step(1);
    start = 1'b0;
    check("b2b_run2_idle", 32'(a_idle), 0);
    step(5);
    check("b2b_done2_early", 32'(a_done), 0);
    step(1);
    check("b2b_done2", 32'(a_done), 1);
    check("b2b_ret2",  a_ret,       3);
    step(3);

    // ---- Reset mid-run aborts; a restart then completes correctly ----
    load(1, -2, 3, -4, 5, 6, -7, 8);
    start = 1'b1; bias = 32'd10;
    step(1);
    start = 1'b0;
    step(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("mid_rst_idle", 32'(a_idle),  1);
    check("mid_rst_ret",  a_ret,        0);
    check("mid_rst_ce",   32'(a_dce),   0);
    check("mid_rst_addr", 32'(a_daddr), 0);
    for (int i = 0; i < 6; i++) begin
      check("mid_rst_no_done", 32'(a_done), 0);
      step(1);
    end
    start = 1'b1; bias = 32'd10;
    step(1);
    start = 1'b0;
    step(6);
    check("restart_done", 32'(a_done), 1);
    check("restart_ret",  a_ret,       32'(-50));
    step(2);

    // ---- N_IN=1: 7*-3 + 100 = 79, done 4 cycles after acceptance ----
    load(7, 0, 0, 0, -3, 0, 0, 0);
    start = 1'b1; bias = 32'd100;
    step(1);
    start = 1'b0;
    check("n1_ce",   32'(c_dce),   1);
    check("n1_addr", 32'(c_daddr), 0);
    step(2);
    check("n1_done_early", 32'(c_done), 0);
    step(1);
    check("n1_done",  32'(c_done),  1);
    check("n1_ready", 32'(c_ready), 1);
    check("n1_ret",   c_ret,        79);
    step(1);
    check("n1_idle", 32'(c_idle), 1);
    step(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/myproject_dense_mac_seq.md
Name: myproject_dense_mac_seq

Overview:
- Sequencer for one dense-layer neuron. It time-multiplexes the single 16s×9s→25 multiplier core over N_IN input/weight pairs.
- Data and weights are read from 1-cycle-latency ROM/BRAM ports; products are accumulated onto a bias.
- The result is returned under the ap_ctrl_hs handshake.
- Sits between the layer's input buffer and weight ROM and the activation stage.

Parameters:
- N_IN, 4, number of products per dot product (≥1).
- ADDR_WIDTH, 2, address width, ≥ clog2(N_IN), minimum 1.
- ACC_WIDTH, 32, signed accumulator/return width (≥25).

Ports:
- ap_clk  in  1  clock, all logic on rising edge.
- ap_rst  in  1  synchronous reset, active-high.
- ap_start  in  1  start request (ap_ctrl_hs).
- ap_done  out  1  one-cycle pulse: ap_return valid.
- ap_idle  out  1  high while in IDLE.
- ap_ready  out  1  one-cycle pulse, coincident with ap_done.
- bias  in  ACC_WIDTH  signed bias, sampled on start acceptance.
- data_address0  out  ADDR_WIDTH  input buffer read address.
- data_ce0  out  1  input buffer read enable.
- data_q0  in  16  signed data, valid the cycle after ce0.
- weight_address0  out  ADDR_WIDTH  weight ROM read address (equal to data_address0).
- weight_ce0  out  1  weight ROM read enable (equal to data_ce0).
- weight_q0  in  9  signed weight, valid the cycle after ce0.
- ap_return  out  ACC_WIDTH  signed dot product + bias.

Behaviour:
- Reset values (ap_rst=1): state=IDLE, ap_idle=1, ap_done=0, ap_ready=0, ce0s=0, addresses=0, acc=0, ap_return=0, pipeline valid bits=0.
  - Reset mid-run aborts the run with no ap_done; the next start after reset behaves as from power-up.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - ap_idle=1.
  - If ap_start=1 in cycle T: go to RUN, acc<=sign-extended bias, idx<=0.
- RUN (cycles T+1..T+N_IN):
  - ce0=1, address=idx, idx increments each cycle.
  - After the cycle with idx=N_IN-1, go to DRAIN.
- Datapath:
  - Stage 1 (cycle after ce0): data_q0 × weight_q0 through the multiplier core; 25-bit product registered into prod_r with valid bit.
  - Stage 2: acc <= acc + sign_extend(prod_r) when prod_r valid.
- DRAIN:
  - ce0=0.
  - Hold 2 cycles (T+N_IN+1, T+N_IN+2) until the final product is accumulated at the end of T+N_IN+2.
- DONE (cycle T+N_IN+3):
  - ap_done=1, ap_ready=1, ap_idle=0.
  - ap_return updated at DONE entry and held until the next DONE.
  - Next state is IDLE.
- Latency: ap_done exactly N_IN+3 cycles after the start-accept cycle. No overlap between runs.
  - ap_start held high → back-to-back runs spaced N_IN+4 cycles apart (one IDLE cycle between).
- Arithmetic:
  - Full-precision 25-bit product.
  - Accumulator wraps two's-complement modulo 2^ACC_WIDTH. No saturation or rounding.
- Inputs:
  - data_q0/weight_q0 are sampled only in the cycle after ce0=1; otherwise ignored.
  - bias is sampled only at start acceptance.
  - ap_start outside IDLE is ignored.
- Addresses: when ce0=0 they hold their last value. Never exceed N_IN-1 (no wrap within a run).

Decomposition:
- Shared package: state encoding constants (IDLE/RUN/DRAIN/DONE) and the product width constant 25.
- Sub-module: instantiate the existing combinational multiplier core myproject_mul_mul_16s_9s_25_1_1 (din0=data_q0, din1=weight_q0, dout→prod_r D input).
- Counter, FSM and accumulator stay in this module.

Test Plan:
- Basic, N_IN=4: data [1,-2,3,-4], weights [5,6,-7,8], bias=10, start at cycle T → ap_return=-50, ap_done/ap_ready pulse at exactly T+7, addresses 0,1,2,3 at T+1..T+4.
- Extremes, ACC_WIDTH=32: all data=-32768, all weights=-256, bias=0 → ap_return=33554432. Same with ACC_WIDTH=25 → ap_return=0 (wrap).
- Back-to-back: ap_start held high, second bias=-1, data all 1, weights all 1 → first done at T+7, ap_idle=1 at T+8, second done at T+15 with ap_return=3.
- Reset mid-run: assert ap_rst at T+3 for 1 cycle → no ap_done, ap_return=0, ap_idle=1. A restart gives correct results.
- Start ignored while busy: pulse ap_start at T+4 → no extra run, single done at T+7. ap_return held stable through 10 IDLE cycles.
- N_IN=1, ADDR_WIDTH=1: data=7, weight=-3, bias=100 → ap_return=79, done at T+4.
